// File: rtl/interrupt_pending_unit_pkg.sv
// Shared interrupt constants used by the pending unit and the downstream priority encoder.
package interrupt_pending_unit_pkg;

   localparam int          IRQ_COUNT        = 32;
   localparam int          IRQ_INDEX_WIDTH  = 5;
   localparam logic        IRQ_MODE_LEVEL   = 1'b0;
   localparam logic        IRQ_MODE_EDGE    = 1'b1;
   localparam logic [31:0] MASK_RESET_VALUE = 32'h0;

   typedef logic [IRQ_COUNT-1:0] irq_vec_t;

   function automatic irq_vec_t irq_onehot(input logic [IRQ_INDEX_WIDTH-1:0] idx);
      return irq_vec_t'(1) << idx;
   endfunction

endpackage

// File: rtl/interrupt_pending_unit_capture_cell.sv
// One interrupt line: synchroniser chain, previous-sample flop and level/edge capture flop.
module interrupt_pending_unit_capture_cell
   import interrupt_pending_unit_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetN,
   input  logic irq_i,
   input  logic edge_mode_i,
   input  logic ack_i,
   output logic captured_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   captured_q;
   logic                   captured_d;
   logic                   sync_bit;
   logic                   rise;

   assign sync_bit = sync_q[SYNC_STAGES-1];
   assign rise     = sync_bit & ~prev_q;

   // A new edge beats a simultaneous acknowledge so no request is lost.
   always_comb begin
      captured_d = captured_q;
      if (edge_mode_i == IRQ_MODE_LEVEL) begin
         captured_d = sync_bit;
      end else if (rise) begin
         captured_d = 1'b1;
      end else if (ack_i) begin
         captured_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         captured_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_i};
         prev_q     <= sync_bit;
         captured_q <= captured_d;
      end
   end

   assign captured_o = captured_q;

endmodule

// File: rtl/interrupt_pending_unit.sv
// Interrupt pending unit: per-line capture, software mask, registered pending vector and request.
module interrupt_pending_unit
   import interrupt_pending_unit_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic [IRQ_COUNT-1:0]       irqLines,
   input  logic [IRQ_COUNT-1:0]       edgeMode,
   input  logic                       maskWriteEnable,
   input  logic [IRQ_COUNT-1:0]       maskWriteData,
   input  logic                       ackValid,
   input  logic [IRQ_INDEX_WIDTH-1:0] ackIndex,
   output logic [IRQ_COUNT-1:0]       mask,
   output logic [IRQ_COUNT-1:0]       pendingSignals,
   output logic                       interruptRequest
);

   irq_vec_t ack_vec;
   irq_vec_t captured;
   irq_vec_t mask_q,    mask_d;
   irq_vec_t pending_q, pending_d;

   assign ack_vec = ackValid ? irq_onehot(ackIndex) : '0;

   for (genvar i = 0; i < IRQ_COUNT; i++) begin : g_cell
      interrupt_pending_unit_capture_cell #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_cell (
         .clk         (clk),
         .resetN      (resetN),
         .irq_i       (irqLines[i]),
         .edge_mode_i (edgeMode[i]),
         .ack_i       (ack_vec[i]),
         .captured_o  (captured[i])
      );
   end

   // Pending uses the mask as it stood before this edge, so a write shows one cycle later.
   always_comb begin
      mask_d    = maskWriteEnable ? maskWriteData : mask_q;
      pending_d = captured & mask_q;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         mask_q    <= MASK_RESET_VALUE;
         pending_q <= '0;
      end else begin
         mask_q    <= mask_d;
         pending_q <= pending_d;
      end
   end

   assign mask             = mask_q;
   assign pendingSignals   = pending_q;
   assign interruptRequest = |pending_q;

endmodule

// File: tb/tb_interrupt_pending_unit.sv
// Scoreboard bench: directed scenarios plus random traffic checked against a vector-level model.
module tb_interrupt_pending_unit;

   localparam int S = 2;

   typedef struct packed {
      logic [31:0] pend;
      logic [31:0] msk;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic [31:0] irqLines = '0;
   logic [31:0] edgeMode = '0;
   logic        maskWriteEnable = 1'b0;
   logic [31:0] maskWriteData = '0;
   logic        ackValid = 1'b0;
   logic [4:0]  ackIndex = '0;
   logic [31:0] mask;
   logic [31:0] pendingSignals;
   logic        interruptRequest;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t        exp_q[$];
   logic [31:0] hist[$];
   logic [31:0] m_prev = '0, m_cap = '0, m_mask = '0, m_pend = '0;

   interrupt_pending_unit #(.SYNC_STAGES(S)) dut (
      .clk              (clk),
      .resetN           (resetN),
      .irqLines         (irqLines),
      .edgeMode         (edgeMode),
      .maskWriteEnable  (maskWriteEnable),
      .maskWriteData    (maskWriteData),
      .ackValid         (ackValid),
      .ackIndex         (ackIndex),
      .mask             (mask),
      .pendingSignals   (pendingSignals),
      .interruptRequest (interruptRequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: sync is the input seen S edges ago; edge lines latch rises, level lines copy sync.
   task automatic model_edge();
      logic [31:0] sync, rise, clr, nxt_cap;
      if (!resetN) begin
         hist.delete();
         for (int k = 0; k < S; k++) hist.push_back('0);
         m_prev = '0; m_cap = '0; m_mask = '0; m_pend = '0;
      end else begin
         sync    = hist[S-1];
         rise    = sync & ~m_prev;
         clr     = ackValid ? (32'd1 << ackIndex) : 32'd0;
         nxt_cap = (~edgeMode & sync) | (edgeMode & (rise | (m_cap & ~clr)));
         m_pend  = m_cap & m_mask;
         m_mask  = maskWriteEnable ? maskWriteData : m_mask;
         m_cap   = nxt_cap;
         m_prev  = sync;
         hist.push_front(irqLines);
         void'(hist.pop_back());
      end
      exp_q.push_back('{pend: m_pend, msk: m_mask});
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pending", pendingSignals, e.pend);
            chk("sb_irq", {31'd0, interruptRequest}, {31'd0, |e.pend});
            chk("sb_mask", mask, e.msk);
         end
      end
   end

   initial begin : stim
      for (int k = 0; k < S; k++) hist.push_back('0);
      tick(); tick();
      chk("reset_pending", pendingSignals, 32'h0);
      chk("reset_mask", mask, 32'h0);
      chk("reset_irq", {31'd0, interruptRequest}, 32'h0);

      resetN = 1'b1; maskWriteEnable = 1'b1; maskWriteData = '1;
      tick(); maskWriteEnable = 1'b0; tick();

      // Level line 5: latency out and back.
      irqLines[5] = 1'b1;
      repeat (3) tick();
      chk("lvl_lat_early", pendingSignals, 32'h0);
      tick();
      chk("lvl_lat", pendingSignals, 32'h20);
      chk("lvl_irq", {31'd0, interruptRequest}, 32'h1);
      irqLines[5] = 1'b0;
      repeat (3) tick();
      chk("lvl_drop_early", pendingSignals, 32'h20);
      tick();
      chk("lvl_drop", pendingSignals, 32'h0);

      // Edge line 3: pulse, hold, acknowledge.
      edgeMode[3] = 1'b1; tick();
      irqLines[3] = 1'b1; repeat (3) tick();
      irqLines[3] = 1'b0; repeat (4) tick();
      chk("edge_hold", pendingSignals, 32'h8);
      ackValid = 1'b1; ackIndex = 5'd3; tick(); ackValid = 1'b0;
      chk("ack_same_edge", pendingSignals, 32'h8);
      tick();
      chk("ack_next_edge", pendingSignals, 32'h0);

      // Edge line 7 captured while masked, then revealed.
      maskWriteEnable = 1'b1; maskWriteData = 32'h0; edgeMode[7] = 1'b1; tick();
      maskWriteEnable = 1'b0;
      irqLines[7] = 1'b1; repeat (2) tick();
      irqLines[7] = 1'b0; repeat (4) tick();
      chk("masked_hidden", pendingSignals, 32'h0);
      maskWriteEnable = 1'b1; maskWriteData = 32'h80; tick(); maskWriteEnable = 1'b0;
      chk("mask_write_edge", pendingSignals, 32'h0);
      tick();
      chk("unmasked", pendingSignals, 32'h80);
      ackValid = 1'b1; ackIndex = 5'd7; tick(); ackValid = 1'b0; tick();
      maskWriteEnable = 1'b1; maskWriteData = '1; tick(); maskWriteEnable = 1'b0; tick();

      // Line 9: set coincides with ack, then ack on a high level line.
      edgeMode[9] = 1'b1; irqLines[9] = 1'b1; repeat (2) tick();
      ackValid = 1'b1; ackIndex = 5'd9; tick(); ackValid = 1'b0; tick();
      chk("set_beats_ack", pendingSignals, 32'h200);
      edgeMode[9] = 1'b0; repeat (2) tick();
      ackValid = 1'b1; ackIndex = 5'd9; tick(); ackValid = 1'b0; tick();
      chk("level_ack_ignored", pendingSignals, 32'h200);
      irqLines[9] = 1'b0; repeat (4) tick();

      // Lines 2 and 30 pending, then a mid-run reset.
      edgeMode[30] = 1'b1; irqLines[2] = 1'b1; irqLines[30] = 1'b1; repeat (5) tick();
      chk("two_pending", pendingSignals, 32'h40000004);
      resetN = 1'b0; tick(); resetN = 1'b1;
      chk("mid_reset", pendingSignals, 32'h0);
      maskWriteEnable = 1'b1; maskWriteData = '1; tick(); maskWriteEnable = 1'b0;
      repeat (6) tick();
      irqLines[2] = 1'b0; irqLines[30] = 1'b0;

      // Line 12 held high across mode toggles.
      irqLines[12] = 1'b1; repeat (5) tick();
      edgeMode[12] = 1'b1; repeat (4) tick();
      edgeMode[12] = 1'b0; irqLines[12] = 1'b0; repeat (5) tick();

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         irqLines        = irqLines ^ ($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0) edgeMode = $urandom;
         maskWriteEnable = ($urandom_range(0, 7) == 0);
         maskWriteData   = $urandom | $urandom;
         ackValid        = ($urandom_range(0, 2) == 0);
         ackIndex        = 5'($urandom_range(0, 31));
         resetN          = ($urandom_range(0, 79) != 0);
         tick();
      end
      resetN = 1'b1; ackValid = 1'b0; maskWriteEnable = 1'b0;
      tick();
      #10;
      if (exp_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
